commit_trace_arbiter: RTL and testbench

Multi-lane retirement serializer between the out-of-order core's commit stage and a single-port trace consumer (spike-log writer, RVFI shim, or debug UART). It accepts up to `CHANNELS` in-order commits per cycle into a circular buffer and drains them one per cycle. Back-pressure goes to the ROB. It also tracks the halt instruction and the segment-marker window (start/stop markers) with cycle and instruction counters, so IPC can be measured in hardware.

---
 rtl/commit_trace_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_commit_trace_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_arbiter.sv
// Commit-to-trace serializer: folds up to CHANNELS in-order retirements per cycle
// into a circular buffer, drains one per cycle, and measures a marker-delimited segment.
module commit_trace_arbiter #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      commit_valid,
  input  logic [CHANNELS*64-1:0]   commit_order,
  input  logic [CHANNELS*32-1:0]   commit_inst,
  input  logic [CHANNELS*32-1:0]   commit_pc,
  output logic                     commit_ready,
  output logic                     trace_valid,
  output logic [63:0]              trace_order,
  output logic [31:0]              trace_inst,
  output logic [31:0]              trace_pc,
  input  logic                     trace_ready,
  output logic                     halt,
  output logic                     seg_active,
  output logic                     seg_done,
  output logic [63:0]              seg_cycles,
  output logic [63:0]              seg_insts,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {
    SEG_IDLE = 2'd0,
    SEG_RUN  = 2'd1,
    SEG_DONE = 2'd2
  } seg_state_t;

  function automatic logic f_is_halt(input logic [31:0] inst);
    return (inst == 32'h0000_0063) || (inst == 32'h0000_006f) || (inst == 32'hF000_2013);
  endfunction

  function automatic logic f_is_start(input logic [31:0] inst);
    return inst == 32'h0010_2013;
  endfunction

  function automatic logic f_is_stop(input logic [31:0] inst);
    return inst == 32'h0020_2013;
  endfunction

  logic [63:0]   r_order   [DEPTH];
  logic [31:0]   r_inst    [DEPTH];
  logic [31:0]   r_pc      [DEPTH];
  logic          r_is_halt [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_halt_seen;
  logic          r_halt;
  logic          r_overflow;
  seg_state_t    r_seg_state;
  logic [63:0]   r_seg_cycles;
  logic [63:0]   r_seg_insts;

  logic [CW-1:0] w_free;
  logic [NW-1:0] w_n_raw;
  logic          w_halt_hit;
  logic [NW-1:0] w_n;
  logic          w_drain;
  logic [CW-1:0] w_count_nxt;
  seg_state_t    w_seg_state_nxt;
  logic [63:0]   w_seg_cycles_nxt;
  logic [63:0]   w_seg_insts_nxt;

  assign w_free       = CW'(DEPTH) - r_count;
  assign commit_ready = rst && !r_halt_seen && (w_free >= CW'(CHANNELS));
  assign trace_valid  = (r_count != '0);
  assign w_drain      = trace_valid && trace_ready;
  assign w_n          = commit_ready ? w_n_raw : '0;
  assign w_count_nxt  = r_count + CW'(w_n) - CW'(w_drain);

  assign trace_order  = r_order[r_rd_ptr];
  assign trace_inst   = r_inst[r_rd_ptr];
  assign trace_pc     = r_pc[r_rd_ptr];
  assign halt         = r_halt;
  assign overflow_err = r_overflow;
  assign seg_cycles   = r_seg_cycles;
  assign seg_insts    = r_seg_insts;

  // Length of the contiguous valid prefix, cut short just after the first halt lane.
  always_comb begin
    logic v_stop;
    v_stop     = 1'b0;
    w_n_raw    = '0;
    w_halt_hit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (v_stop || !commit_valid[i]) begin
        v_stop = 1'b1;
      end else begin
        w_n_raw = NW'(i + 1);
        if (f_is_halt(commit_inst[i*32 +: 32])) begin
          w_halt_hit = 1'b1;
          v_stop     = 1'b1;
        end else begin
          w_halt_hit = w_halt_hit;
        end
      end
    end
  end

  // Buffer storage; only lanes inside the accepted prefix are written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (NW'(i) < w_n) begin
        r_order[r_wr_ptr + PW'(i)]   <= commit_order[i*64 +: 64];
        r_inst[r_wr_ptr + PW'(i)]    <= commit_inst[i*32 +: 32];
        r_pc[r_wr_ptr + PW'(i)]      <= commit_pc[i*32 +: 32];
        r_is_halt[r_wr_ptr + PW'(i)] <= f_is_halt(commit_inst[i*32 +: 32]);
      end
    end
  end

  // Pointers, occupancy and sticky status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_halt_seen <= 1'b0;
      r_halt      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_n);
      r_rd_ptr <= r_rd_ptr + PW'(w_drain);
      r_count  <= w_count_nxt;
      if (commit_ready && w_halt_hit) begin
        r_halt_seen <= 1'b1;
      end
      if (w_drain && r_is_halt[r_rd_ptr]) begin
        r_halt <= 1'b1;
      end
      if ((commit_valid != '0) && !commit_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Segment state and counters register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seg_state  <= SEG_IDLE;
      r_seg_cycles <= 64'd0;
      r_seg_insts  <= 64'd0;
    end else begin
      r_seg_state  <= w_seg_state_nxt;
      r_seg_cycles <= w_seg_cycles_nxt;
      r_seg_insts  <= w_seg_insts_nxt;
    end
  end

  // Segment next state: walk accepted lanes in order so start/stop pairs in one cycle resolve.
  always_comb begin
    w_seg_state_nxt  = r_seg_state;
    w_seg_cycles_nxt = r_seg_cycles;
    w_seg_insts_nxt  = r_seg_insts;
    case (r_seg_state)
      SEG_RUN:  w_seg_cycles_nxt = r_seg_cycles + 64'd1;
      SEG_IDLE: w_seg_cycles_nxt = r_seg_cycles;
      SEG_DONE: w_seg_cycles_nxt = r_seg_cycles;
      default:  w_seg_state_nxt  = SEG_IDLE;
    endcase
    for (int i = 0; i < CHANNELS; i++) begin
      if (NW'(i) < w_n) begin
        if (f_is_start(commit_inst[i*32 +: 32])) begin
          w_seg_state_nxt  = SEG_RUN;
          w_seg_cycles_nxt = 64'd0;
          w_seg_insts_nxt  = 64'd0;
        end else if (w_seg_state_nxt == SEG_RUN) begin
          w_seg_insts_nxt = w_seg_insts_nxt + 64'd1;
          if (f_is_stop(commit_inst[i*32 +: 32])) begin
            w_seg_state_nxt = SEG_DONE;
          end else begin
            w_seg_state_nxt = SEG_RUN;
          end
        end else begin
          w_seg_insts_nxt = w_seg_insts_nxt;
        end
      end else begin
        w_seg_insts_nxt = w_seg_insts_nxt;
      end
    end
  end

  // Segment status decode.
  always_comb begin
    seg_active = 1'b0;
    seg_done   = 1'b0;
    case (r_seg_state)
      SEG_RUN:  seg_active = 1'b1;
      SEG_DONE: seg_done   = 1'b1;
      default: begin
        seg_active = 1'b0;
        seg_done   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_commit_trace_arbiter.sv
// Randomized scoreboard bench for commit_trace_arbiter: a queue-based reference model
// predicts status outputs each cycle; a negedge monitor checks every drained trace entry.
module tb_commit_trace_arbiter;

  localparam int CH = 2;
  localparam int DP = 8;
  localparam logic [31:0] START_M = 32'h0010_2013;
  localparam logic [31:0] STOP_M  = 32'h0020_2013;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     commit_valid;
  logic [CH*64-1:0]  commit_order;
  logic [CH*32-1:0]  commit_inst;
  logic [CH*32-1:0]  commit_pc;
  logic              commit_ready;
  logic              trace_valid;
  logic [63:0]       trace_order;
  logic [31:0]       trace_inst;
  logic [31:0]       trace_pc;
  logic              trace_ready;
  logic              halt;
  logic              seg_active;
  logic              seg_done;
  logic [63:0]       seg_cycles;
  logic [63:0]       seg_insts;
  logic              overflow_err;

  commit_trace_arbiter #(.CHANNELS(CH), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_order(commit_order),
    .commit_inst(commit_inst), .commit_pc(commit_pc),
    .commit_ready(commit_ready),
    .trace_valid(trace_valid), .trace_order(trace_order),
    .trace_inst(trace_inst), .trace_pc(trace_pc), .trace_ready(trace_ready),
    .halt(halt), .seg_active(seg_active), .seg_done(seg_done),
    .seg_cycles(seg_cycles), .seg_insts(seg_insts), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        sb[$];
  ent_t        mq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          m_halt_seen, m_halt, m_ovf;
  int          m_seg;
  logic [63:0] m_cyc, m_ins;
  logic [63:0] next_order = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_halt(input logic [31:0] x);
    return (x == 32'h0000_0063) || (x == 32'h0000_006f) || (x == 32'hF000_2013);
  endfunction

  function automatic logic [31:0] plain_inst();
    logic [31:0] x;
    do x = $urandom; while (is_halt(x) || x == START_M || x == STOP_M);
    return x;
  endfunction

  function automatic logic [CH*32-1:0] plain2();
    return {plain_inst(), plain_inst()};
  endfunction

  function automatic logic [31:0] rand_inst();
    int r;
    r = $urandom_range(0, 99);
    if (r < 5)       return START_M;
    else if (r < 10) return STOP_M;
    else if (r < 11) return (r[0]) ? 32'h0000_0063 : 32'hF000_2013;
    else             return plain_inst();
  endfunction

  function automatic bit m_ready();
    return (rst === 1'b1) && !m_halt_seen && ((DP - mq.size()) >= CH);
  endfunction

  task automatic check_outputs();
    check("commit_ready", commit_ready, m_ready());
    check("trace_valid", trace_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("head_order", trace_order, mq[0].order);
      check("head_inst", trace_inst, mq[0].inst);
      check("head_pc", trace_pc, mq[0].pc);
    end
    check("halt", halt, m_halt);
    check("overflow_err", overflow_err, m_ovf);
    check("seg_active", seg_active, m_seg == 1);
    check("seg_done", seg_done, m_seg == 2);
    check("seg_cycles", seg_cycles, m_cyc);
    check("seg_insts", seg_insts, m_ins);
  endtask

  // Reference: FIFO queue of entries plus the segment rules applied lane by lane.
  task automatic model_step();
    ent_t e;
    bit   rdy;
    bit   halt_next;
    halt_next = 1'b0;
    if (rst !== 1'b1) begin
      mq.delete(); sb.delete();
      m_halt_seen = 1'b0; m_halt = 1'b0; m_ovf = 1'b0;
      m_seg = 0; m_cyc = 64'd0; m_ins = 64'd0;
      return;
    end
    rdy = m_ready();
    if (mq.size() != 0 && trace_ready) begin
      e = mq.pop_front();
      if (is_halt(e.inst)) halt_next = 1'b1;
    end
    if (m_seg == 1) m_cyc = m_cyc + 64'd1;
    if (rdy) begin
      for (int i = 0; i < CH; i++) begin
        if (!commit_valid[i]) break;
        e.order = commit_order[i*64 +: 64];
        e.inst  = commit_inst[i*32 +: 32];
        e.pc    = commit_pc[i*32 +: 32];
        mq.push_back(e);
        sb.push_back(e);
        next_order = next_order + 64'd1;
        if (e.inst == START_M) begin
          m_seg = 1; m_cyc = 64'd0; m_ins = 64'd0;
        end else if (m_seg == 1) begin
          m_ins = m_ins + 64'd1;
          if (e.inst == STOP_M) m_seg = 2;
        end
        if (is_halt(e.inst)) begin
          m_halt_seen = 1'b1;
          break;
        end
      end
    end else if (commit_valid != '0) begin
      m_ovf = 1'b1;
    end
    if (halt_next) m_halt = 1'b1;
  endtask

  task automatic cycle(input logic r, input logic [CH-1:0] v, input logic tr,
                       input logic [CH*32-1:0] insts);
    rst          = r;
    commit_valid = v;
    trace_ready  = tr;
    commit_inst  = insts;
    for (int i = 0; i < CH; i++) begin
      commit_order[i*64 +: 64] = next_order + 64'(i);
      commit_pc[i*32 +: 32]    = $urandom;
    end
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake on the trace port must match the oldest scoreboard entry.
  always @(negedge clk) begin
    ent_t e;
    if (rst === 1'b1 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got drained order %0h expected no entry", trace_order);
      end else begin
        e = sb.pop_front();
        check("mon_order", trace_order, e.order);
        check("mon_inst", trace_inst, e.inst);
        check("mon_pc", trace_pc, e.pc);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b0; commit_valid = '0; commit_order = '0; commit_inst = '0;
    commit_pc = '0; trace_ready = 1'b0;
    m_halt_seen = 1'b0; m_halt = 1'b0; m_ovf = 1'b0;
    m_seg = 0; m_cyc = 64'd0; m_ins = 64'd0;
    @(posedge clk); #1;

    // Reset hold, then the first cycle after release.
    repeat (3) cycle(1'b0, '0, 1'b0, plain2());
    cycle(1'b1, '0, 1'b0, plain2());

    // Two lanes per cycle, orders 0..11, consumer always ready.
    guard = 0;
    while (next_order < 64'd12 && guard < 40) begin
      cycle(1'b1, m_ready() ? 2'b11 : 2'b00, 1'b1, plain2());
      guard++;
    end
    repeat (10) cycle(1'b1, '0, 1'b1, plain2());

    // Fill to full with the consumer stalled, then force commits.
    repeat (5) cycle(1'b1, m_ready() ? 2'b11 : 2'b00, 1'b0, plain2());
    repeat (3) cycle(1'b1, 2'b11, 1'b0, plain2());
    check("overflow_set", overflow_err, 1'b1);
    check("full_valid", trace_valid, 1'b1);
    repeat (10) cycle(1'b1, '0, 1'b1, plain2());

    // Mid-operation reset discards buffered entries.
    repeat (2) cycle(1'b1, 2'b11, 1'b0, plain2());
    cycle(1'b0, '0, 1'b0, plain2());
    check("rst_discard_valid", trace_valid, 1'b0);
    check("rst_clear_ovf", overflow_err, 1'b0);

    // Wrap-around: 20 single-lane commits, consumer toggling.
    next_order = 64'd0;
    guard = 0;
    while (next_order < 64'd20 && guard < 80) begin
      cycle(1'b1, m_ready() ? 2'b01 : 2'b00, guard[0], plain2());
      guard++;
    end
    repeat (12) cycle(1'b1, '0, 1'b1, plain2());

    // Segment: start, 10 instructions over 6 cycles, stop, then 5 frozen cycles.
    cycle(1'b0, '0, 1'b0, plain2());
    cycle(1'b1, 2'b01, 1'b1, {plain_inst(), START_M});
    repeat (4) cycle(1'b1, 2'b11, 1'b1, plain2());
    repeat (2) cycle(1'b1, 2'b01, 1'b1, plain2());
    cycle(1'b1, 2'b01, 1'b1, {plain_inst(), STOP_M});
    check("seg_insts_stop", seg_insts, 64'd11);
    check("seg_cycles_stop", seg_cycles, 64'd7);
    check("seg_done_stop", seg_done, 1'b1);
    repeat (5) cycle(1'b1, '0, 1'b1, plain2());
    check("seg_insts_frozen", seg_insts, 64'd11);
    check("seg_cycles_frozen", seg_cycles, 64'd7);

    // Halt in lane 0 drops lane 1 and closes the commit port.
    cycle(1'b0, '0, 1'b0, plain2());
    cycle(1'b1, 2'b11, 1'b0, {plain_inst(), 32'h0000_006f});
    check("halt_blocks_ready", commit_ready, 1'b0);
    repeat (2) cycle(1'b1, '0, 1'b0, plain2());
    check("halt_before_drain", halt, 1'b0);
    cycle(1'b1, '0, 1'b1, plain2());
    check("halt_after_drain", halt, 1'b1);
    check("halt_single_entry", trace_valid, 1'b0);
    repeat (2) cycle(1'b1, '0, 1'b1, plain2());

    // Randomized rounds, each ending in a reset with the buffer likely non-empty.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 180; c++) begin
        cycle(1'b1, CH'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
              {rand_inst(), rand_inst()});
      end
      cycle(1'b0, '0, 1'b0, plain2());
    end

    cycle(1'b1, '0, 1'b0, plain2());
    repeat (6) cycle(1'b1, 2'b11, 1'b1, {rand_inst(), rand_inst()});
    repeat (12) cycle(1'b1, '0, 1'b1, plain2());
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
